legv8_instr_encoder: RTL and testbench
======================================

Name: legv8_instr_encoder

Overview:
- Inverse of the immediate sign-extension path. Takes a decoded instruction (format, opcode, register fields, 64-bit immediate) and range-checks the immediate.
- Truncates the immediate into its LEGv8 field and packs a 32-bit instruction word.
- Emits the word with a sequential instruction-memory write address.
- Sits in front of imem as the program loader used by benches and the boot path.

Parameters:
- ADDR_W, 6, width of the imem word address.
- DEPTH, 64, number of imem words; address wraps at DEPTH-1 (DEPTH <= 2**ADDR_W).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous: address counter, err_count and the output register are set to 0; any input presented that cycle is dropped.
- in_valid  in  1  input word valid.
- in_ready  out  1  encoder can accept.
- in_fmt  in  3  fmt_t: R, I, D, CB, B.
- in_op  in  11  opcode, left-aligned; upper bits used per format.
- in_rd  in  5  Rd/Rt.
- in_rn  in  5  Rn.
- in_rm  in  5  Rm (R only).
- in_imm  in  64  immediate, two's complement.
- out_valid  out  1  packed word valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  packed instruction.
- out_addr  out  ADDR_W  imem word address for out_instr.
- out_err  out  1  immediate out of range for this word.
- err_count  out  8  saturating count of emitted words with out_err=1.

Behaviour:
- Reset values (async, reset_n=0): out_valid=0, out_instr=0, out_addr=0, out_err=0, err_count=0, internal address counter=0.
- Handshake:
  - One-entry output register; in_ready = !out_valid || out_ready.
  - Transfer happens when in_valid && in_ready; the result is registered the next clk, so latency is 1 cycle.
  - Outputs hold stable while out_valid && !out_ready.
  - Full throughput when out_ready is held high.
- Packing, bit ranges of out_instr:
  - R: op[10:0]→[31:21], rm→[20:16], imm[5:0]→[15:10] (shamt, unsigned 0..63), rn→[9:5], rd→[4:0].
  - I: op[10:1]→[31:22], imm[11:0]→[21:10] (unsigned 0..4095), rn, rd.
  - D: op[10:0]→[31:21], imm[8:0]→[20:12] (signed -256..255), [11:10]=00, rn, rd.
  - CB: op[10:3]→[31:24], imm[18:0]→[23:5] (signed -2^18..2^18-1), rd→[4:0].
  - B: op[10:5]→[31:26], imm[25:0]→[25:0] (signed -2^25..2^25-1).
- Range check:
  - Signed fields: in_imm must equal the sign-extension of its truncated field.
  - Unsigned fields: all bits above the field must be 0.
  - Undefined in_fmt encodings count as an error.
- On error: out_instr=0, out_err=1, the word is still emitted and the address still advances (keeps imem layout deterministic). err_count increments on the output transfer and saturates at 255.
- Address: out_addr takes the counter value at accept; the counter increments per accepted input and wraps from DEPTH-1 to 0.
- Reset or clear mid-transfer: the pending output is discarded, with no partial word.

Optional Feature:
- Macro BRANCH_BYTE_OFFSET_EN.
  - Defined: CB/B in_imm is a byte offset. imm[1:0] must be 00, otherwise error. The field packs imm>>2, and the range check is applied to imm>>2.
  - Undefined: CB/B in_imm is a word offset, packed directly.

Decomposition:
- Package legv8_pkg holds:
  - fmt_t enum.
  - Field width constants: D_IMM_W=9, CB_IMM_W=19, B_IMM_W=26, I_IMM_W=12, SHAMT_W=6.
  - Opcode constants shared with signext and the decoder.
- One natural sub-module, imm_range_check: combinational. Takes fmt and imm, returns field bits and err. Reusable by an assembler-side checker.

Test Plan:
- LDUR X1,[X2,#-8]: fmt=D, op=11'b11111000010, rd=1, rn=2, imm=-8 → out_instr=0xF85F8041, out_err=0, out_addr=0.
- ADDI X3,X4,#4095: fmt=I, op[10:1]=10'b1001000100, rn=4, rd=3 → 0x913FFC83. Same with imm=4096 → out_instr=0, out_err=1, err_count=1, out_addr advances.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_instr/out_addr stable, one transfer each once out_ready=1, no drop or duplicate.
- B imm=-1, op[10:5]=6'b000101 → 0x17FFFFFF.
  - With BRANCH_BYTE_OFFSET_EN: imm=-4 gives the same word; imm=-2 → out_err=1.
- Wrap: DEPTH=64, 65 back-to-back accepts → out_addr runs 0..63 then 0.
- reset_n low for 1 cycle with out_valid=1 mid-stream → out_valid=0, counter=0, err_count=0 immediately (async). The next accept is emitted at address 0.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: instruction formats, immediate field widths,
// opcode constants and helpers for immediate range checking.
// Used by the encoder, the sign-extension unit and the decoder.
package legv8_pkg;

    // Instruction format selector; encodings 5..7 are undefined.
    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_CB = 3'd3,
        FMT_B  = 3'd4
    } fmt_t;

    // Immediate field widths inside the 32-bit instruction word
    localparam int D_IMM_W  = 9;
    localparam int CB_IMM_W = 19;
    localparam int B_IMM_W  = 26;
    localparam int I_IMM_W  = 12;
    localparam int SHAMT_W  = 6;

    // Widest immediate field; the range checker returns fields right-aligned in this width
    localparam int FIELD_W = B_IMM_W;

    // Opcodes, left-aligned in 11 bits (unused low bits are zero)
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    // True when v equals the sign-extension of its low w bits
    function automatic logic sext_fits(input logic [63:0] v, input int w);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 64; b++) begin
            if (b >= w - 1 && v[b] != v[63]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // True when all bits of v at and above position w are zero
    function automatic logic zext_fits(input logic [63:0] v, input int w);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 64; b++) begin
            if (b >= w && v[b]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/legv8_instr_encoder_imm_range_check.sv
// imm_range_check: combinational immediate range checker and truncator.
// Returns the immediate field bits (right-aligned) and an error flag.
// Optional macro BRANCH_BYTE_OFFSET_EN: CB/B immediates are byte offsets
// that must be word aligned and are packed as imm>>2.
module imm_range_check
    import legv8_pkg::*;
(
    input  logic [2:0]         fmt,
    input  logic [63:0]        imm,
    output logic [FIELD_W-1:0] field,
    output logic               err
);

    logic [63:0] br_imm;
    logic        br_misaligned;

`ifdef BRANCH_BYTE_OFFSET_EN
    assign br_imm        = {{2{imm[63]}}, imm[63:2]};
    assign br_misaligned = |imm[1:0];
`else
    assign br_imm        = imm;
    assign br_misaligned = 1'b0;
`endif

    // Select the field for the format and flag immediates that do not fit it
    always_comb begin
        field = '0;
        err   = 1'b0;
        case (fmt)
            FMT_R: begin
                field[SHAMT_W-1:0] = imm[SHAMT_W-1:0];
                err                = !zext_fits(imm, SHAMT_W);
            end
            FMT_I: begin
                field[I_IMM_W-1:0] = imm[I_IMM_W-1:0];
                err                = !zext_fits(imm, I_IMM_W);
            end
            FMT_D: begin
                field[D_IMM_W-1:0] = imm[D_IMM_W-1:0];
                err                = !sext_fits(imm, D_IMM_W);
            end
            FMT_CB: begin
                field[CB_IMM_W-1:0] = br_imm[CB_IMM_W-1:0];
                err                 = br_misaligned || !sext_fits(br_imm, CB_IMM_W);
            end
            FMT_B: begin
                field[B_IMM_W-1:0] = br_imm[B_IMM_W-1:0];
                err                = br_misaligned || !sext_fits(br_imm, B_IMM_W);
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: packs decoded LEGv8 instructions into 32-bit words
// with sequential imem write addresses, behind a one-entry output register.
// Out-of-range immediates emit a zero word with out_err set; the address
// still advances so the imem layout stays deterministic.
// Optional macro BRANCH_BYTE_OFFSET_EN (handled in imm_range_check).
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [10:0]       in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    logic [FIELD_W-1:0] field;
    logic               imm_err;
    logic [31:0]        packed_word;
    logic [ADDR_W-1:0]  addr_reg;
    logic               accept;
    logic               drain;

    imm_range_check u_imm_range_check (
        .fmt   (in_fmt),
        .imm   (in_imm),
        .field (field),
        .err   (imm_err)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // Place opcode, register and immediate fields at their format's bit positions
    always_comb begin
        packed_word = '0;
        case (in_fmt)
            FMT_R:  packed_word = {in_op[10:0], in_rm, field[SHAMT_W-1:0], in_rn, in_rd};
            FMT_I:  packed_word = {in_op[10:1], field[I_IMM_W-1:0], in_rn, in_rd};
            FMT_D:  packed_word = {in_op[10:0], field[D_IMM_W-1:0], 2'b00, in_rn, in_rd};
            FMT_CB: packed_word = {in_op[10:3], field[CB_IMM_W-1:0], in_rd};
            FMT_B:  packed_word = {in_op[10:5], field[B_IMM_W-1:0]};
            default: packed_word = '0;
        endcase
    end

    // imem write address counter: one step per accepted input, wraps at DEPTH-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg <= '0;
        end else if (clear) begin
            addr_reg <= '0;
        end else if (accept) begin
            if (addr_reg == ADDR_W'(DEPTH - 1)) begin
                addr_reg <= '0;
            end else begin
                addr_reg <= addr_reg + 1'b1;
            end
        end
    end

    // One-entry output register; refilled on accept, emptied on drain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= imm_err ? 32'h0 : packed_word;
            out_addr  <= addr_reg;
            out_err   <= imm_err;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of emitted words that carried an error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if (drain && out_err && err_count != 8'hFF) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Testbench for legv8_instr_encoder: directed vectors, a scoreboard model
// built from the instruction field rules, and literal checks on known words.
// Honours BRANCH_BYTE_OFFSET_EN when the same macro is defined for the bench.
module tb_legv8_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = 3'd0;
    logic [10:0] in_op = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rn = '0;
    logic [4:0]  in_rm = '0;
    logic [63:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [5:0]  out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;

    legv8_instr_encoder #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rn     (in_rn),
        .in_rm     (in_rm),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected word from the field rules, using plain integer arithmetic
    function automatic void model(input logic [2:0] f, input logic [10:0] op,
                                  input logic [4:0] rd, input logic [4:0] rn,
                                  input logic [4:0] rm, input logic [63:0] imm,
                                  output logic [31:0] w, output logic e);
        longint s;
        longint v;
        longint r;
        s = signed'(imm);
        v = s;
        r = 0;
        e = 1'b0;
        case (f)
            3'd0: begin
                if (imm > 64'd63) e = 1'b1;
                r = (longint'(op) << 21) + (longint'(rm) << 16) + (s << 10) + (longint'(rn) << 5) + longint'(rd);
            end
            3'd1: begin
                if (imm > 64'd4095) e = 1'b1;
                r = ((longint'(op) >> 1) << 22) + (s << 10) + (longint'(rn) << 5) + longint'(rd);
            end
            3'd2: begin
                if (s < -256 || s > 255) e = 1'b1;
                r = (longint'(op) << 21) + ((s & 64'h1FF) << 12) + (longint'(rn) << 5) + longint'(rd);
            end
            3'd3, 3'd4: begin
`ifdef BRANCH_BYTE_OFFSET_EN
                if ((s & 3) != 0) e = 1'b1;
                v = s / 4;
`endif
                if (f == 3'd3) begin
                    if (v < -262144 || v > 262143) e = 1'b1;
                    r = ((longint'(op) >> 3) << 24) + ((v & 64'h7FFFF) << 5) + longint'(rd);
                end else begin
                    if (v < -(longint'(1) << 25) || v > (longint'(1) << 25) - 1) e = 1'b1;
                    r = ((longint'(op) >> 5) << 26) + (v & 64'h3FFFFFF);
                end
            end
            default: e = 1'b1;
        endcase
        w = e ? 32'h0 : r[31:0];
    endfunction

    typedef struct {
        logic [31:0] w;
        logic        e;
        logic [5:0]  a;
    } exp_t;

    exp_t        sb[$];
    logic [5:0]  m_addr = '0;
    logic [7:0]  m_errc = '0;

    // Compare outputs against the model every cycle, then predict the next edge
    always @(negedge clk) begin
        exp_t        x;
        logic [31:0] w;
        logic        er;
        logic        take;
        if (!reset_n) begin
            sb.delete();
            m_addr = '0;
            m_errc = '0;
            tests++;
            if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 6'd0 || out_err !== 1'b0 || err_count !== 8'd0) begin
                fails++;
                $display("FAIL reset_state: valid=%b instr=%h addr=%0d err=%b errcnt=%0d, required all zero",
                         out_valid, out_instr, out_addr, out_err, err_count);
            end
        end else begin
            tests++;
            if (sb.size() > 0) begin
                x = sb[0];
                if (out_valid !== 1'b1 || out_instr !== x.w || out_err !== x.e || out_addr !== x.a) begin
                    fails++;
                    $display("FAIL scoreboard: valid=%b instr=%h err=%b addr=%0d, required valid=1 instr=%h err=%b addr=%0d",
                             out_valid, out_instr, out_err, out_addr, x.w, x.e, x.a);
                end
            end else if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL scoreboard_idle: out_valid=%b, required 0", out_valid);
            end
            tests++;
            if (in_ready !== (sb.size() == 0 || out_ready)) begin
                fails++;
                $display("FAIL in_ready: got %b, required %b", in_ready, (sb.size() == 0 || out_ready));
            end
            tests++;
            if (err_count !== m_errc) begin
                fails++;
                $display("FAIL err_count: got %0d, required %0d", err_count, m_errc);
            end
            if (clear) begin
                sb.delete();
                m_addr = '0;
                m_errc = '0;
            end else begin
                take = in_valid && (sb.size() == 0 || out_ready);
                if (sb.size() > 0 && out_ready) begin
                    if (sb[0].e && m_errc != 8'd255) m_errc = m_errc + 8'd1;
                    void'(sb.pop_front());
                end
                if (take) begin
                    model(in_fmt, in_op, in_rd, in_rn, in_rm, in_imm, w, er);
                    x.w = w;
                    x.e = er;
                    x.a = m_addr;
                    sb.push_back(x);
                    m_addr = (m_addr == 6'd63) ? 6'd0 : m_addr + 6'd1;
                end
            end
        end
    end

    // Present one input (called at posedge+1) and wait, bounded, until it is taken
    task automatic send(input logic [2:0] f, input logic [10:0] op, input logic [4:0] rd,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [63:0] imm);
        int   n;
        logic ok;
        in_fmt = f; in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
        in_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        in_valid = 1'b0;
    endtask

    // Literal check of the word presented at the next falling edge
    task automatic check_lit(input string name, input logic [31:0] w, input logic e, input logic [5:0] a);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_instr !== w || out_err !== e || out_addr !== a) begin
            fails++;
            $display("FAIL %s: valid=%b instr=%h err=%b addr=%0d, required valid=1 instr=%h err=%b addr=%0d",
                     name, out_valid, out_instr, out_err, out_addr, w, e, a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input logic [7:0] c);
        @(negedge clk);
        tests++;
        if (err_count !== c) begin
            fails++;
            $display("FAIL %s: err_count=%0d, required %0d", name, err_count, c);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [10:0] OP_LDUR_T = 11'b11111000010;
    localparam logic [10:0] OP_ADDI_T = 11'b10010001000;
    localparam logic [10:0] OP_ADD_T  = 11'b10001011000;
    localparam logic [10:0] OP_CBZ_T  = 11'b10110100000;
    localparam logic [10:0] OP_B_T    = 11'b00010100000;

    initial begin
        logic [63:0] br_m1;
        logic [63:0] br_bad;
`ifdef BRANCH_BYTE_OFFSET_EN
        br_m1  = -64'sd4;
        br_bad = -64'sd2;
`else
        br_m1  = -64'sd1;
        br_bad = 64'd1 << 25;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        send(3'd2, OP_LDUR_T, 5'd1, 5'd2, 5'd0, -64'sd8);
        check_lit("ldur_neg8", 32'hF85F8041, 1'b0, 6'd0);
        send(3'd1, OP_ADDI_T, 5'd3, 5'd4, 5'd0, 64'd4095);
        check_lit("addi_4095", 32'h913FFC83, 1'b0, 6'd1);
        send(3'd1, OP_ADDI_T, 5'd3, 5'd4, 5'd0, 64'd4096);
        check_lit("addi_4096_err", 32'h0, 1'b1, 6'd2);
        check_cnt("err_count_after_addi", 8'd1);

        send(3'd0, OP_ADD_T, 5'd7, 5'd6, 5'd5, 64'd3);
        check_lit("add_shamt3", 32'h8B050CC7, 1'b0, 6'd3);
        send(3'd0, OP_ADD_T, 5'd7, 5'd6, 5'd5, 64'd64);
        check_lit("add_shamt64_err", 32'h0, 1'b1, 6'd4);
        send(3'd2, OP_LDUR_T, 5'd1, 5'd2, 5'd0, -64'sd256);
        check_lit("ldur_neg256", 32'hF8500041, 1'b0, 6'd5);
        send(3'd2, OP_LDUR_T, 5'd1, 5'd2, 5'd0, 64'd256);
        check_lit("ldur_256_err", 32'h0, 1'b1, 6'd6);
        send(3'd3, OP_CBZ_T, 5'd9, 5'd0, 5'd0, br_m1);
        check_lit("cbz_minus1", 32'hB4FFFFE9, 1'b0, 6'd7);
        send(3'd4, OP_B_T, 5'd0, 5'd0, 5'd0, br_m1);
        check_lit("b_minus1", 32'h17FFFFFF, 1'b0, 6'd8);
        send(3'd4, OP_B_T, 5'd0, 5'd0, 5'd0, br_bad);
        check_lit("b_bad_err", 32'h0, 1'b1, 6'd9);
        send(3'd7, OP_B_T, 5'd0, 5'd0, 5'd0, 64'd0);
        check_lit("fmt7_err", 32'h0, 1'b1, 6'd10);
        check_cnt("err_count_after_errs", 8'd5);

        // Backpressure: one word held, the next one waits three cycles
        out_ready = 1'b0;
        send(3'd2, OP_LDUR_T, 5'd1, 5'd2, 5'd0, -64'sd8);
        in_fmt = 3'd1; in_op = OP_ADDI_T; in_rd = 5'd3; in_rn = 5'd4; in_imm = 64'd4095;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || out_instr !== 32'hF85F8041 || out_addr !== 6'd11) begin
                fails++;
                $display("FAIL backpressure_hold: in_ready=%b instr=%h addr=%0d, required 0 F85F8041 11",
                         in_ready, out_instr, out_addr);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'd1, OP_ADDI_T, 5'd3, 5'd4, 5'd0, 64'd4095);
        check_lit("backpressure_next", 32'h913FFC83, 1'b0, 6'd12);

        // Asynchronous reset while a word is held
        out_ready = 1'b0;
        send(3'd2, OP_LDUR_T, 5'd1, 5'd2, 5'd0, -64'sd8);
        reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || err_count !== 8'd0 || out_addr !== 6'd0) begin
            fails++;
            $display("FAIL async_reset: valid=%b errcnt=%0d addr=%0d, required 0 0 0", out_valid, err_count, out_addr);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(3'd2, OP_LDUR_T, 5'd1, 5'd2, 5'd0, -64'sd8);
        check_lit("after_reset_addr0", 32'hF85F8041, 1'b0, 6'd0);

        // Clear drops the input presented in the same cycle
        send(3'd1, OP_ADDI_T, 5'd3, 5'd4, 5'd0, 64'd5000);
        in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || err_count !== 8'd0) begin
            fails++;
            $display("FAIL clear_drop: valid=%b errcnt=%0d, required 0 0", out_valid, err_count);
        end
        @(posedge clk);
        #1;

        // Wrap: 65 back-to-back accepts, addresses 0..63 then 0
        in_fmt = 3'd1; in_op = OP_ADDI_T; in_rd = 5'd3; in_rn = 5'd4;
        in_valid = 1'b1;
        for (int k = 0; k < 65; k++) begin
            in_imm = 64'(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_lit("wrap_addr0", 32'h91010083, 1'b0, 6'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
